// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Size decode helpers are shared by the FSM and the lane aligner.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Unlisted size codes fall through to word.
    function automatic logic is_byte(input logic [1:0] sz);
        return sz == F3_B[1:0];
    endfunction

    function automatic logic is_half(input logic [1:0] sz);
        return sz == F3_H[1:0];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [1:0] off);
        logic r;
        r = 1'b0;
        unique case (1'b1)
            is_byte(sz): r = 1'b0;
            is_half(sz): r = off[0];
            default:     r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes/replicated write data, and
// load extraction with sign/zero extension.
module lsu_lane_align (
    input  logic [2:0]  st_f3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_strb_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_f3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);
    import lsu_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    // Store side: strobe and lane-replicated data.
    always_comb begin
        st_strb_o  = STRB_W;
        st_wdata_o = st_data_i;
        unique case (1'b1)
            is_byte(st_f3_i[1:0]): begin
                st_strb_o  = STRB_B << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            is_half(st_f3_i[1:0]): begin
                st_strb_o  = STRB_H << {st_off_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the lane, then extend.
    always_comb begin
        sext   = ~ld_f3_i[2];
        half_v = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        unique case (ld_off_i)
            2'd0:    byte_v = ld_rdata_i[7:0];
            2'd1:    byte_v = ld_rdata_i[15:8];
            2'd2:    byte_v = ld_rdata_i[23:16];
            default: byte_v = ld_rdata_i[31:24];
        endcase
        ld_data_o = ld_rdata_i;
        unique case (1'b1)
            is_byte(ld_f3_i[1:0]):
                ld_data_o = {{24{sext & byte_v[7]}}, byte_v};
            is_half(ld_f3_i[1:0]):
                ld_data_o = {{16{sext & half_v[15]}}, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: stalling request/ready bus access with timeout.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              bus_error,
    output logic              misaligned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);
    import lsu_pkg::*;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q;
    logic [ADDR_W-1:2] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       load_data_q;
    logic              bus_error_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              access;
    logic [3:0]        st_strb;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_ext;

    assign access = mem_read | mem_write;
    assign cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    lsu_lane_align u_align (
        .st_f3_i    (funct3),
        .st_off_i   (addr[1:0]),
        .st_data_i  (store_data),
        .st_strb_o  (st_strb),
        .st_wdata_o (st_wdata),
        .ld_f3_i    (f3_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (bus_rdata),
        .ld_data_o  (ld_ext)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;
    logic mis_in;
    assign mis_in     = is_misaligned(funct3[1:0], addr[1:0]);
    assign misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

    // Stall is gated by reset so an abort releases the PC at once.
    assign stall = rst & ((state_q == BUS) |
                          ((state_q == IDLE) & access));

    assign bus_req   = (state_q == BUS);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign load_data = load_data_q;
    assign bus_error = bus_error_q;

    // Transaction FSM, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            we_q        <= 1'b0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            load_data_q <= 32'h0;
            bus_error_q <= 1'b0;
            cnt_q       <= 16'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            bus_error_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (access) begin
                        addr_q  <= addr[ADDR_W-1:2];
                        off_q   <= addr[1:0];
                        f3_q    <= funct3;
                        we_q    <= mem_write;
                        wstrb_q <= mem_write ? st_strb : 4'h0;
                        wdata_q <= st_wdata;
                        cnt_q   <= 16'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (mis_in) begin
                            misaligned_q <= 1'b1;
                            load_data_q  <= 32'h0;
                            state_q      <= DONE;
                        end else begin
                            state_q <= BUS;
                        end
`else
                        state_q <= BUS;
`endif
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        if (!we_q) begin
                            load_data_q <= ld_ext;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        bus_error_q <= 1'b1;
                        load_data_q <= 32'h0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level model.
// Per-cycle bus checks plus literal expectations per test vector.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] load_data;
    logic        stall;
    logic        bus_error;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int errs = 0;
    int total = 0;

    logic        exp_active = 1'b0;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;

    logic [31:0] r_ld;
    logic [31:0] r_addr;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata;
    logic        r_we;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .bus_error  (bus_error),
        .misaligned (misaligned),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected bus fields and load result from size/offset arithmetic.
    task automatic model(input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rw);
        int nb;
        int off;
        logic [63:0] m;
        logic [63:0] v;
        case (f3[1:0])
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            default: nb = 4;
        endcase
        off = int'(a[1:0]);
        off = off - (off % nb);
        e_addr = a & 32'hFFFF_FFFC;
        e_we = wr;
        e_strb = wr ? 4'(((1 << nb) - 1) << off) : 4'h0;
        if (nb == 1)
            e_wdata = 32'(sd[7:0]) * 32'h0101_0101;
        else if (nb == 2)
            e_wdata = 32'(sd[15:0]) * 32'h0001_0001;
        else
            e_wdata = sd;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = (64'(rw) >> (8 * off)) & m;
        if (!f3[2] && v[8 * nb - 1])
            v = v | ~m;
        e_ld = v[31:0];
    endtask

    // Bus fields must match the model on every request cycle.
    always begin
        @(negedge clk);
        #2;
        if (exp_active && bus_req) begin
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_we", 32'(bus_we), 32'(e_we));
            chk("bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
            chk("bus_wdata", bus_wdata, e_wdata);
            chk("stall_in_bus", 32'(stall), 32'd1);
        end
    end

    task automatic run(input string tag, input bit rd, input bit wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rw,
                       input int waits, input bit never);
        int  stalls;
        int  w;
        bit  done;
        int  exp_stalls;
        model(wr, f3, a, sd, rw);
        exp_stalls = 1 + (never ? 4 : waits + 1);
        r_addr = 32'hx;
        r_strb = 4'hx;
        r_wdata = 32'hx;
        r_we = 1'bx;
        exp_active = 1'b1;
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        funct3 = f3;
        addr = a;
        store_data = sd;
        bus_rdata = rw;
        bus_ready = 1'b0;
        stalls = 0;
        w = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus_req) begin
                r_addr = bus_addr;
                r_strb = bus_wstrb;
                r_wdata = bus_wdata;
                r_we = bus_we;
                bus_ready = !never && (w >= waits);
                w++;
            end else begin
                bus_ready = 1'b0;
            end
            if (stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        if (!done)
            chk({tag, " done_bound"}, 32'd0, 32'd1);
        chk({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
        chk({tag, " bus_error"}, 32'(bus_error), 32'(never));
        chk({tag, " misaligned"}, 32'(misaligned), 32'd0);
        if (rd && !wr)
            chk({tag, " load_data"}, load_data, never ? 32'h0 : e_ld);
        r_ld = load_data;
        mem_read = 1'b0;
        mem_write = 1'b0;
        bus_ready = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " idle_stall"}, 32'(stall), 32'd0);
        chk({tag, " idle_req"}, 32'(bus_req), 32'd0);
        chk({tag, " err_pulse"}, 32'(bus_error), 32'd0);
        exp_active = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst load_data", load_data, 32'h0);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst bus_error", 32'(bus_error), 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;

        run("LB", 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 2, 0);
        chk("LB lit ld", r_ld, 32'hFFFF_FF80);
        chk("LB lit addr", r_addr, 32'h0000_1000);

        run("LHU", 1, 0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 0);
        chk("LHU lit ld", r_ld, 32'h0000_BEEF);

        run("SB", 0, 1, 3'b000, 32'h3001, 32'h1234_56AB, 32'h0, 0, 0);
        chk("SB lit we", 32'(r_we), 32'd1);
        chk("SB lit strb", 32'(r_strb), 32'h2);
        chk("SB lit wdata", r_wdata, 32'hABAB_ABAB);

        run("SH", 0, 1, 3'b001, 32'h3002, 32'h0000_CAFE, 32'h0, 1, 0);
        chk("SH lit strb", 32'(r_strb), 32'hC);
        chk("SH lit wdata", r_wdata, 32'hCAFE_CAFE);

        run("LHmis", 1, 0, 3'b001, 32'h1003, 32'h0, 32'h8001_7FFF, 1, 0);
        chk("LHmis lit ld", r_ld, 32'hFFFF_8001);

        run("LBU", 1, 0, 3'b100, 32'h1001, 32'h0, 32'h0000_F000, 0, 0);
        chk("LBU lit ld", r_ld, 32'h0000_00F0);

        run("LWmis", 1, 0, 3'b010, 32'h4002, 32'h0, 32'hDEAD_BEEF, 0, 0);
        chk("LWmis lit addr", r_addr, 32'h0000_4000);
        chk("LWmis lit ld", r_ld, 32'hDEAD_BEEF);

        run("TMO", 1, 0, 3'b010, 32'h6000, 32'h0, 32'h5555_5555, 0, 1);
        chk("TMO lit ld", r_ld, 32'h0);

        run("RW", 1, 1, 3'b010, 32'h7000, 32'h1122_3344, 32'h0, 0, 0);
        chk("RW lit we", 32'(r_we), 32'd1);
        chk("RW lit strb", 32'(r_strb), 32'hF);

        run("ILL", 1, 0, 3'b011, 32'h1001, 32'h0, 32'h1234_5678, 0, 0);
        chk("ILL lit ld", r_ld, 32'h1234_5678);
        chk("ILL lit addr", r_addr, 32'h0000_1000);

        @(negedge clk);
        mem_read = 1'b1;
        funct3 = 3'b010;
        addr = 32'h5000;
        bus_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("RST in_bus", 32'(bus_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("RST req_drop", 32'(bus_req), 32'd0);
        chk("RST stall_drop", 32'(stall), 32'd0);
        chk("RST load_data", load_data, 32'h0);
        @(negedge clk);
        mem_read = 1'b0;
        #1 rst = 1'b1;

        run("SWpost", 0, 1, 3'b010, 32'h8004, 32'hA5A5_A5A5, 32'h0, 1, 0);
        chk("SWpost lit strb", 32'(r_strb), 32'hF);
        chk("SWpost lit addr", r_addr, 32'h0000_8004);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
